// File: rtl/bus_mux_arbiter_pkg.sv
// Shared definitions for the 4:1 tri-state bus mux arbiter: state encodings,
// default timing parameters and the requester count.
package bus_mux_arbiter_pkg;

  localparam int NUM_REQ      = 4;
  localparam int DEF_MAX_HOLD = 8;
  localparam int DEF_TURN_CYC = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_mux_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: first asserted request scanning
// last+1, last+2, ... modulo 4, so the previous owner has lowest priority.
module rr_pick4
  import bus_mux_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         win,
  output logic               any
);

  logic [1:0] idx;

  // Scan from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    win = last;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) win = idx;
    end
    any = |req;
  end

endmodule

// File: rtl/bus_mux_arbiter.sv
// Round-robin arbiter/sequencer driving the select pair and output enable of a
// shared 4:1 tri-state bus mux, with an OE-low turnaround gap between owners.
module bus_mux_arbiter
  import bus_mux_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int TURN_CYC = DEF_TURN_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         sel,
  output logic               oe,
  output logic               busy
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int TURN_W = $clog2(TURN_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         last_q, last_d;
  logic               oe_q, oe_d;
  logic               busy_q, busy_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [TURN_W-1:0]  turn_q, turn_d;

  logic [1:0] win;
  logic       any;

  rr_pick4 u_pick (
    .req  (req),
    .last (last_q),
    .win  (win),
    .any  (any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d = ST_GRANT;
          gnt_d   = onehot4(win);
          sel_d   = win;
          last_d  = win;
          oe_d    = 1'b1;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        hold_d = hold_q + HOLD_W'(1);
        if (!req[last_q] || (hold_q == HOLD_LAST)) begin
          // sel is left untouched so the mux select never moves while OE is high.
          state_d = ST_TURN;
          gnt_d   = '0;
          oe_d    = 1'b0;
          turn_d  = '0;
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) begin
          if (any) begin
            state_d = ST_GRANT;
            gnt_d   = onehot4(win);
            sel_d   = win;
            last_d  = win;
            oe_d    = 1'b1;
            hold_d  = '0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= 2'd3;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign oe   = oe_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Self-checking bench for bus_mux_arbiter: ownership-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_bus_mux_arbiter;

  localparam int MAX_HOLD = 8;
  localparam int TURN_CYC = 1;

  bit         clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       oe;
  logic       busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  bus_mux_arbiter #(.MAX_HOLD(MAX_HOLD), .TURN_CYC(TURN_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .oe    (oe),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: who owns the bus, for how long, and how much gap remains.
  int m_owner = -1;
  int m_held  = 0;
  int m_gap   = 0;
  int m_last  = 3;
  int m_sel   = 0;

  function automatic int rr_next(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_last = 3; m_sel = 0;
    end else if (m_owner >= 0) begin
      m_held++;
      if (!req[m_owner] || m_held == MAX_HOLD) begin
        m_owner = -1;
        m_gap   = TURN_CYC;
      end
    end else begin
      if (m_gap > 0) m_gap--;
      if (m_gap == 0 && req != 4'b0) begin
        m_owner = rr_next(m_last, req);
        m_last  = m_owner;
        m_sel   = m_owner;
        m_held  = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_gnt",  int'(gnt),  (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("model_sel",  int'(sel),  m_sel);
    chk("model_oe",   int'(oe),   (m_owner >= 0) ? 1 : 0);
    chk("model_busy", int'(busy), (m_owner >= 0 || m_gap > 0) ? 1 : 0);
    chk("inv_oe_eq_or_gnt", int'(oe), int'(|gnt));
    chk("inv_gnt_onehot0", int'($onehot0(gnt)), 1);
  end

  task automatic expect_out(input string name, input logic [3:0] e_gnt,
                            input logic [1:0] e_sel, input logic e_oe, input logic e_busy);
    chk({name, "_gnt"},  int'(gnt),  int'(e_gnt));
    chk({name, "_sel"},  int'(sel),  int'(e_sel));
    chk({name, "_oe"},   int'(oe),   int'(e_oe));
    chk({name, "_busy"}, int'(busy), int'(e_busy));
  endtask

  int  run_own[8];
  int  run_len[8];
  int  gap_len[8];
  int  nrun;
  bit  prev_oe;

  initial begin
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 8; i++) begin run_own[i] = -1; run_len[i] = 0; gap_len[i] = 0; end
    #1 rst_n = 1'b0;
    #1 expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Saturation straight out of reset: owners 0,1,2,3,0 with 8-cycle grants.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nrun = 0;
    prev_oe = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (oe) begin
        if (!prev_oe && nrun < 8) begin
          run_own[nrun] = int'(sel);
          nrun++;
        end
        if (nrun > 0) run_len[nrun-1]++;
      end else if (nrun > 0) begin
        gap_len[nrun-1]++;
      end
      prev_oe = oe;
    end
    chk("sat_runs", nrun, 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("sat_owner%0d", k), run_own[k], k % 4);
      chk($sformatf("sat_len%0d", k), run_len[k], 8);
    end
    for (int k = 0; k < 4; k++) chk($sformatf("sat_gap%0d", k), gap_len[k], 1);
    req = 4'b0000;
    @(negedge clk);
    expect_out("sat_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single request from IDLE.
    req = 4'b0100;
    @(negedge clk);
    expect_out("single_grant", 4'b0100, 2'd2, 1'b1, 1'b1);
    req = 4'b0000;
    @(negedge clk);
    expect_out("single_turn", 4'b0000, 2'd2, 1'b0, 1'b1);
    @(negedge clk);
    expect_out("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Round-robin after owner 2: 0101 sampled on the final TURN edge picks 0.
    req = 4'b0100;
    @(negedge clk);
    expect_out("rr_own2", 4'b0100, 2'd2, 1'b1, 1'b1);
    req = 4'b0001;
    @(negedge clk);
    expect_out("rr_turn", 4'b0000, 2'd2, 1'b0, 1'b1);
    req = 4'b0101;
    @(negedge clk);
    expect_out("rr_pick0", 4'b0001, 2'd0, 1'b1, 1'b1);

    // Handover from owner 1 to owner 3.
    req = 4'b0010;
    @(negedge clk);
    expect_out("ho_turn0", 4'b0000, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    expect_out("ho_own1", 4'b0010, 2'd1, 1'b1, 1'b1);
    req = 4'b1000;
    @(negedge clk);
    expect_out("ho_turn1", 4'b0000, 2'd1, 1'b0, 1'b1);
    @(negedge clk);
    expect_out("ho_own3", 4'b1000, 2'd3, 1'b1, 1'b1);

    // Async reset in the middle of a grant.
    req = 4'b1010;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 expect_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_out("post_rst", 4'b0010, 2'd1, 1'b1, 1'b1);

    // Sole requester at hold expiry is re-granted after the gap.
    req = 4'b0010;
    repeat (7) @(negedge clk);
    expect_out("solo_last", 4'b0010, 2'd1, 1'b1, 1'b1);
    @(negedge clk);
    expect_out("solo_gap", 4'b0000, 2'd1, 1'b0, 1'b1);
    @(negedge clk);
    expect_out("solo_regrant", 4'b0010, 2'd1, 1'b1, 1'b1);

    req = 4'b0000;
    repeat (4) @(negedge clk);
    expect_out("final_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
